// File: rtl/logic_op_sequencer.sv
// Issues register-register logical instructions to an external combinational
// logical unit: reads both sources, executes, and writes the result back.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready for an instruction; latch fields on handshake
//   RD    | present rs/rt to the register file
//   OPND  | register file data valid; capture operands A and B
//   EXEC  | drive logical unit; capture result R and zero flag
//   WB    | write R to rd (suppressed for r0); pulse done
//   ERR   | rejected instruction; pulse done and illegal
module logic_op_sequencer #(
    parameter int         WIDTH        = 32,
    parameter int         RA_W         = 5,
    parameter logic [5:0] LOGIC_OPCODE = 6'b000001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr,
    output logic [RA_W-1:0]  rf_rd_addr1,
    output logic [RA_W-1:0]  rf_rd_addr2,
    input  logic [WIDTH-1:0] rf_rd_data1,
    input  logic [WIDTH-1:0] rf_rd_data2,
    output logic [WIDTH-1:0] lu_in1,
    output logic [WIDTH-1:0] lu_in2,
    output logic [1:0]       lu_op,
    input  logic [WIDTH-1:0] lu_out,
    output logic             rf_we,
    output logic [RA_W-1:0]  rf_wr_addr,
    output logic [WIDTH-1:0] rf_wr_data,
    output logic             done,
    output logic             illegal,
    output logic             zero
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_OPND = 3'd2,
        S_EXEC = 3'd3,
        S_WB   = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [RA_W-1:0]  rs_q, rt_q, rd_q;
    logic [1:0]       funct_q;
    logic [WIDTH-1:0] a_q, b_q, r_q;
    logic             zero_q;

    logic accept;
    logic instr_legal;

    assign accept      = (state_q == S_IDLE) && instr_valid;
    assign instr_legal = (instr[31:26] == LOGIC_OPCODE) && (instr[10:2] == 9'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            funct_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            zero_q  <= 1'b0;
        end else begin
            // Fields are latched for every accepted word so later changes to instr are inert
            if (accept) begin
                rs_q    <= RA_W'(instr[25:21]);
                rt_q    <= RA_W'(instr[20:16]);
                rd_q    <= RA_W'(instr[15:11]);
                funct_q <= instr[1:0];
            end
            if (state_q == S_OPND) begin
                a_q <= rf_rd_data1;
                b_q <= rf_rd_data2;
            end
            if (state_q == S_EXEC) begin
                r_q    <= lu_out;
                zero_q <= (lu_out == '0);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        rf_rd_addr1 = '0;
        rf_rd_addr2 = '0;
        lu_in1      = '0;
        lu_in2      = '0;
        lu_op       = 2'b00;
        rf_we       = 1'b0;
        rf_wr_addr  = '0;
        rf_wr_data  = '0;
        done        = 1'b0;
        illegal     = 1'b0;

        if (state_q != S_IDLE) begin
            rf_rd_addr1 = rs_q;
            rf_rd_addr2 = rt_q;
        end

        case (state_q)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_d = instr_legal ? S_RD : S_ERR;
                end
            end
            S_RD:   state_d = S_OPND;
            S_OPND: state_d = S_EXEC;
            S_EXEC: begin
                lu_in1  = a_q;
                lu_in2  = b_q;
                lu_op   = funct_q;
                state_d = S_WB;
            end
            S_WB: begin
                done       = 1'b1;
                rf_wr_addr = rd_q;
                rf_wr_data = r_q;
                rf_we      = (rd_q != '0);
                state_d    = S_IDLE;
            end
            S_ERR: begin
                done    = 1'b1;
                illegal = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign zero = zero_q;

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Directed bench for logic_op_sequencer with a synchronous register file and
// a combinational logical unit modelled around the DUT.
module tb_logic_op_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic [4:0]  rf_rd_addr1, rf_rd_addr2;
    logic [31:0] rf_rd_data1, rf_rd_data2;
    logic [31:0] lu_in1, lu_in2;
    logic [1:0]  lu_op;
    logic [31:0] lu_out;
    logic        rf_we;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic        done, illegal, zero;

    logic [31:0] regs [32];
    logic        load_en = 1'b0;
    logic [4:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    int          done_cnt = 0;
    int          we_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    logic_op_sequencer dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
        .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
        .lu_in1(lu_in1), .lu_in2(lu_in2), .lu_op(lu_op), .lu_out(lu_out),
        .rf_we(rf_we), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .done(done), .illegal(illegal), .zero(zero)
    );

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;
    end

    always @(posedge clk) begin
        if (load_en) regs[load_addr] <= load_data;
        else if (rf_we && rf_wr_addr != 5'd0) regs[rf_wr_addr] <= rf_wr_data;
        rf_rd_data1 <= regs[rf_rd_addr1];
        rf_rd_data2 <= regs[rf_rd_addr2];
        if (done) done_cnt <= done_cnt + 1;
        if (rf_we) we_cnt <= we_cnt + 1;
    end

    always_comb begin
        lu_out = '0;
        case (lu_op)
            2'b00: lu_out = lu_in1 & lu_in2;
            2'b01: lu_out = lu_in1 | lu_in2;
            2'b10: lu_out = lu_in1 ^ lu_in2;
            default: lu_out = ~lu_in1;
        endcase
    end

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] s,
                                       input logic [4:0] t, input logic [4:0] d,
                                       input logic [1:0] f);
        return {op, s, t, d, 9'd0, f};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int d0;
        #2 rst = 1'b1;
        tick();
        load_en = 1'b1; load_addr = 5'd1; load_data = 32'hF0F0_F0F0;
        tick();
        load_addr = 5'd2; load_data = 32'hFF00_FF00;
        tick();
        load_en = 1'b0;
        rst = 1'b0;
        d0 = done_cnt;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", instr_ready); end
        checks++; if ({rf_we, done, illegal, zero} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {rf_we, done, illegal, zero}); end
        checks++; if ({rf_rd_addr1, rf_rd_addr2, rf_wr_addr, lu_op} !== 17'd0) begin errors++; $display("FAIL reset_addrs: got %h expected 0", {rf_rd_addr1, rf_rd_addr2, rf_wr_addr, lu_op}); end
        checks++; if ({lu_in1, lu_in2, rf_wr_data} !== 96'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", {lu_in1, lu_in2, rf_wr_data}); end
        checks++; if (done_cnt !== d0) begin errors++; $display("FAIL reset_no_done: got %0d pulses expected 0", done_cnt - d0); end
    endtask

    task automatic test_and;
        instr_valid = 1'b1; instr = mk(6'b000001, 5'd1, 5'd2, 5'd3, 2'b00);
        tick();
        instr_valid = 1'b0; instr = 32'hFFFF_FFFF;
        checks++; if (instr_ready !== 1'b0 || rf_rd_addr1 !== 5'd1 || rf_rd_addr2 !== 5'd2) begin errors++; $display("FAIL and_rd: got ready=%b a1=%0d a2=%0d expected 0 1 2", instr_ready, rf_rd_addr1, rf_rd_addr2); end
        tick();
        checks++; if (instr_ready !== 1'b0 || lu_in1 !== 32'd0) begin errors++; $display("FAIL and_opnd: got ready=%b in1=%h expected 0 0", instr_ready, lu_in1); end
        tick();
        checks++; if (lu_in1 !== 32'hF0F0_F0F0 || lu_in2 !== 32'hFF00_FF00 || lu_op !== 2'b00) begin errors++; $display("FAIL and_exec: got %h %h %b expected f0f0f0f0 ff00ff00 00", lu_in1, lu_in2, lu_op); end
        tick();
        checks++; if ({done, rf_we, illegal, instr_ready} !== 4'b1100) begin errors++; $display("FAIL and_wb_flags: got %b expected 1100", {done, rf_we, illegal, instr_ready}); end
        checks++; if (rf_wr_addr !== 5'd3 || rf_wr_data !== 32'hF000_F000 || zero !== 1'b0) begin errors++; $display("FAIL and_wb_data: got %0d %h z=%b expected 3 f000f000 0", rf_wr_addr, rf_wr_data, zero); end
        tick();
        checks++; if (instr_ready !== 1'b1 || done !== 1'b0 || regs[3] !== 32'hF000_F000) begin errors++; $display("FAIL and_retire: got ready=%b done=%b r3=%h expected 1 0 f000f000", instr_ready, done, regs[3]); end
    endtask

    task automatic test_ops;
        logic [31:0] ins [4];
        logic [31:0] exp_d [4];
        logic        exp_z [4];
        logic [4:0]  dst [4];
        ins[0] = mk(6'b000001, 5'd1, 5'd2, 5'd7,  2'b01); exp_d[0] = 32'hFFF0_FFF0; exp_z[0] = 1'b0; dst[0] = 5'd7;
        ins[1] = mk(6'b000001, 5'd1, 5'd2, 5'd8,  2'b10); exp_d[1] = 32'h0FF0_0FF0; exp_z[1] = 1'b0; dst[1] = 5'd8;
        ins[2] = mk(6'b000001, 5'd1, 5'd2, 5'd9,  2'b11); exp_d[2] = 32'h0F0F_0F0F; exp_z[2] = 1'b0; dst[2] = 5'd9;
        ins[3] = mk(6'b000001, 5'd1, 5'd1, 5'd10, 2'b10); exp_d[3] = 32'h0000_0000; exp_z[3] = 1'b1; dst[3] = 5'd10;
        for (int k = 0; k < 4; k++) begin
            instr_valid = 1'b1; instr = ins[k];
            tick();
            instr_valid = 1'b0;
            tick();
            tick();
            checks++; if (lu_op !== ins[k][1:0]) begin errors++; $display("FAIL ops_exec_op[%0d]: got %b expected %b", k, lu_op, ins[k][1:0]); end
            tick();
            checks++; if (rf_wr_data !== exp_d[k] || zero !== exp_z[k]) begin errors++; $display("FAIL ops_wb[%0d]: got %h z=%b expected %h z=%b", k, rf_wr_data, zero, exp_d[k], exp_z[k]); end
            checks++; if (done !== 1'b1 || rf_we !== 1'b1 || rf_wr_addr !== dst[k]) begin errors++; $display("FAIL ops_we[%0d]: got done=%b we=%b addr=%0d expected 1 1 %0d", k, done, rf_we, rf_wr_addr, dst[k]); end
            tick();
        end
    endtask

    task automatic test_illegal;
        logic [31:0] bad [2];
        int w0;
        bad[0] = mk(6'b000010, 5'd1, 5'd2, 5'd11, 2'b00);
        bad[1] = mk(6'b000001, 5'd1, 5'd2, 5'd11, 2'b00) | 32'h0000_0020;
        for (int k = 0; k < 2; k++) begin
            w0 = we_cnt;
            instr_valid = 1'b1; instr = bad[k];
            tick();
            instr_valid = 1'b0;
            checks++; if ({done, illegal, rf_we, instr_ready} !== 4'b1100) begin errors++; $display("FAIL illegal_err[%0d]: got %b expected 1100", k, {done, illegal, rf_we, instr_ready}); end
            checks++; if (zero !== 1'b1) begin errors++; $display("FAIL illegal_zero_hold[%0d]: got %b expected 1", k, zero); end
            tick();
            checks++; if ({done, illegal, instr_ready} !== 3'b001 || we_cnt !== w0) begin errors++; $display("FAIL illegal_idle[%0d]: got %b writes=%0d expected 001 0", k, {done, illegal, instr_ready}, we_cnt - w0); end
        end
    endtask

    task automatic test_rd_zero;
        instr_valid = 1'b1; instr = mk(6'b000001, 5'd1, 5'd2, 5'd0, 2'b00);
        tick();
        instr_valid = 1'b0;
        tick(); tick(); tick();
        checks++; if (done !== 1'b1 || rf_we !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL rd0_wb: got done=%b we=%b ill=%b expected 1 0 0", done, rf_we, illegal); end
        tick();
    endtask

    task automatic test_reset_mid;
        int d0, w0;
        instr_valid = 1'b1; instr = mk(6'b000001, 5'd1, 5'd2, 5'd5, 2'b01);
        tick();
        instr_valid = 1'b0;
        tick(); tick();
        checks++; if (lu_op !== 2'b01) begin errors++; $display("FAIL mid_exec: got %b expected 01", lu_op); end
        d0 = done_cnt; w0 = we_cnt;
        rst = 1'b1;
        #1;
        checks++; if (instr_ready !== 1'b1 || lu_op !== 2'b00 || lu_in1 !== 32'd0 || zero !== 1'b0) begin errors++; $display("FAIL mid_async: got ready=%b op=%b in1=%h z=%b expected 1 00 0 0", instr_ready, lu_op, lu_in1, zero); end
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        checks++; if (done_cnt !== d0 || we_cnt !== w0 || regs[5] !== 32'd0) begin errors++; $display("FAIL mid_dropped: got done=%0d we=%0d r5=%h expected 0 0 0", done_cnt - d0, we_cnt - w0, regs[5]); end
        instr_valid = 1'b1; instr = mk(6'b000001, 5'd1, 5'd2, 5'd5, 2'b01);
        tick();
        instr_valid = 1'b0;
        tick(); tick(); tick();
        checks++; if (rf_we !== 1'b1 || rf_wr_addr !== 5'd5 || rf_wr_data !== 32'hFFF0_FFF0) begin errors++; $display("FAIL mid_rerun: got we=%b addr=%0d data=%h expected 1 5 fff0fff0", rf_we, rf_wr_addr, rf_wr_data); end
        tick();
    endtask

    task automatic test_back_to_back;
        instr_valid = 1'b1; instr = mk(6'b000001, 5'd1, 5'd2, 5'd4, 2'b10);
        tick();
        instr = mk(6'b000001, 5'd4, 5'd0, 5'd6, 2'b01);
        for (int c = 1; c <= 4; c++) begin
            checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy[%0d]: got %b expected 0", c, instr_ready); end
            if (c < 4) tick();
        end
        checks++; if (rf_wr_addr !== 5'd4 || rf_wr_data !== 32'h0FF0_0FF0 || rf_we !== 1'b1) begin errors++; $display("FAIL b2b_first: got %0d %h we=%b expected 4 0ff00ff0 1", rf_wr_addr, rf_wr_data, rf_we); end
        tick();
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b expected 1", instr_ready); end
        tick();
        instr = 32'hDEAD_BEEF;
        checks++; if (instr_ready !== 1'b0 || rf_rd_addr1 !== 5'd4 || rf_rd_addr2 !== 5'd0) begin errors++; $display("FAIL b2b_rd: got ready=%b a1=%0d a2=%0d expected 0 4 0", instr_ready, rf_rd_addr1, rf_rd_addr2); end
        instr_valid = 1'b0;
        tick(); tick(); tick();
        checks++; if (rf_wr_addr !== 5'd6 || rf_wr_data !== 32'h0FF0_0FF0 || done !== 1'b1) begin errors++; $display("FAIL b2b_second: got %0d %h done=%b expected 6 0ff00ff0 1", rf_wr_addr, rf_wr_data, done); end
        tick();
        checks++; if (regs[6] !== 32'h0FF0_0FF0) begin errors++; $display("FAIL b2b_r6: got %h expected 0ff00ff0", regs[6]); end
    endtask

    initial begin
        test_reset();
        test_and();
        test_ops();
        test_illegal();
        test_rd_zero();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_op_sequencer.md
Name: logic_op_sequencer

Overview:
- Multi-cycle control and datapath front-end that issues register-register logical instructions to the existing combinational logical unit (AND/OR/XOR/NOT, 2-bit op select) and retires its results.
- Accepts one instruction via valid/ready and reads both source registers from the synchronous register file.
- Drives the logical unit operands and op select, captures the result, and writes it back to the destination register.
- Sits between instruction fetch and the register file as the issuing end of the logical unit's operation interface.

Parameters:
- WIDTH, 32, data width of operands, result and register file data.
- RA_W, 5, register address width.
- LOGIC_OPCODE, 6'b000001, opcode value in instr[31:26] that identifies a logical instruction.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept; high only in IDLE.
- instr  in  32  fields: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [1:0] funct, [10:2] must be zero.
- rf_rd_addr1  out  RA_W  source-1 register address.
- rf_rd_addr2  out  RA_W  source-2 register address.
- rf_rd_data1  in  WIDTH  source-1 data, valid one cycle after its address is presented.
- rf_rd_data2  in  WIDTH  source-2 data, valid one cycle after its address is presented.
- lu_in1  out  WIDTH  logical unit operand 1.
- lu_in2  out  WIDTH  logical unit operand 2.
- lu_op  out  2  logical unit select: 00 AND, 01 OR, 10 XOR, 11 NOT(in1).
- lu_out  in  WIDTH  logical unit result, combinational from lu_in1/lu_in2/lu_op.
- rf_we  out  1  write enable, single-cycle pulse.
- rf_wr_addr  out  RA_W  destination register address.
- rf_wr_data  out  WIDTH  write-back data.
- done  out  1  one-cycle pulse when an instruction retires (legal or illegal).
- illegal  out  1  one-cycle pulse, coincident with done, for a rejected instruction.
- zero  out  1  result == 0; registered at EXEC and held until the next EXEC.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All internal registers and all outputs go to 0, except instr_ready, which is 1 because the state is IDLE.
  - An in-flight instruction is dropped with no rf_we and no done.
- States and transitions:
  - IDLE -> RD on instr_valid & instr_ready with a legal instr.
  - IDLE -> ERR on instr_valid & instr_ready with an illegal instr.
  - RD -> OPND, OPND -> EXEC, EXEC -> WB, WB -> IDLE, ERR -> IDLE, all unconditional.
- IDLE:
  - instr_ready=1.
  - On handshake, latch rs, rt, rd, funct into registers.
  - Illegal when any of: opcode != LOGIC_OPCODE, or instr[10:2] != 0.
- RD: rf_rd_addr1=rs, rf_rd_addr2=rt. Both are driven from the latched fields and held in every non-IDLE state; they are 0 in IDLE.
- OPND: capture rf_rd_data1 and rf_rd_data2 into operand registers A and B at the end of the cycle.
- EXEC:
  - lu_in1=A, lu_in2=B, lu_op=funct.
  - Capture lu_out into result register R and update zero at the end of the cycle.
  - lu_in1, lu_in2 and lu_op are 0 outside EXEC.
  - For NOT, rt is still read and lu_in2=B, but the result depends on A only.
- WB:
  - done=1, rf_wr_addr=rd, rf_wr_data=R.
  - rf_we=1 unless rd==0; a write to r0 is suppressed but done still pulses.
  - rf_wr_addr and rf_wr_data are 0 outside WB.
- ERR:
  - done=1 and illegal=1 for one cycle.
  - No register read is used and no rf_we.
  - zero is unchanged.
- Timing:
  - Latency: handshake edge at cycle 0, done high during cycle 4 (IDLE, RD, OPND, EXEC, WB).
  - Throughput: one instruction per 5 cycles; the next accept is earliest in the cycle after WB.
  - ERR retires in 1 cycle after the handshake.
- Handshake rules:
  - instr is sampled only on instr_valid & instr_ready.
  - instr_valid outside IDLE is ignored and does not need to be held.
  - Changes to instr after acceptance have no effect.
- Hazards:
  - Source register == destination register (rs==rd or rt==rd) is safe; operands are captured in OPND before WB.
  - Back-to-back dependent instructions are safe because the write completes in WB before the next RD.
- Arithmetic: pure bitwise operations, no carry, no flags other than zero. All widths are WIDTH; there is no extension.

Test Plan:
- Reset 0->1->0, then hold instr_valid=0 for 10 cycles -> every output 0 except instr_ready=1; done never pulses.
- Apply AND with rs=1 (0xF0F0_F0F0), rt=2 (0xFF00_FF00), rd=3 -> cycle 4: rf_we=1, rf_wr_addr=3, rf_wr_data=0xF000_F000, zero=0, done=1; instr_ready low for cycles 1-4.
- Sweep OR, XOR and NOT with the same operands:
  - OR -> 0xFFF0_FFF0.
  - XOR -> 0x0FF0_0FF0.
  - NOT -> 0x0F0F_0F0F.
  - XOR of r1 with itself -> 0x0000_0000 with zero=1.
- Apply opcode 6'b000010 -> next cycle done=1, illegal=1, rf_we=0; back to IDLE.
- Apply instr with instr[5]=1 -> next cycle done=1, illegal=1, rf_we=0; back to IDLE.
- Apply AND with rd=0 -> cycle 4: done=1, rf_we=0.
- Raise rst during EXEC of an OR to rd=5 -> immediate IDLE, no rf_we, no done; the next instruction executes normally.
- Issue back-to-back XOR r4=r1^r2, then OR r6=r4|r0 with instr_valid held high -> second accepted in the cycle after the first WB; second result equals the first write-back value.
